io_input: RTL

Memory-mapped input device for the simulation test harness: the read-side counterpart of the character-output/power-off port. A host-side producer (testbench or stdin bridge) pushes bytes through a valid/ready handshake into a small FIFO. The CPU drains the FIFO by reading a DATA word and polls occupancy through a STATUS word. It sits on the same data-memory bus and decodes only address bit 2.

---
 rtl/io_input.sv | 103 ++++++++++
 1 files changed

// File: rtl/io_input.sv
// io_input: memory-mapped byte input device for the simulation harness.
// A host producer pushes bytes through a valid/ready handshake into a
// DEPTH-entry FIFO. The CPU pops bytes by reading DATA and polls the
// occupancy by reading STATUS. Only address bit 2 is decoded.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   in_data      byte offered by the producer
//   in_valid     producer has a byte on in_data
//   in_ready     FIFO can accept a byte (depends on count only)
//   in_eof       producer has no further input, reported in STATUS[2]
//   address      0 = DATA, 1 = STATUS
//   read_enable  CPU read this cycle
//   write_enable CPU write this cycle
//   memory_in    CPU write data; bit 0 of a STATUS write flushes the FIFO
//   memory_out   registered read data
//
// STATUS layout: [15:8] count, [2] in_eof, [1] full, [0] nonempty.
module io_input #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_eof,
  input  logic        address,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] memory_in,
  output logic [31:0] memory_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;

  logic          full;
  logic          nonempty;
  logic          flush;
  logic          rd;
  logic          push;
  logic          pop;
  logic [7:0]    count8;
  logic [31:0]   status_word;
  logic          unused_memory_in;

  assign unused_memory_in = &{1'b0, memory_in[31:1]};

  assign full     = (count == CW'(DEPTH));
  assign nonempty = (count != '0);
  assign in_ready = !full;

  assign flush = write_enable && address && memory_in[0];
  // A write cycle suppresses any read so memory_out holds its value.
  assign rd    = read_enable && !write_enable;
  // A flush discards a same-cycle push.
  assign push  = in_valid && in_ready && !flush;
  // Pop is judged on the pre-edge count, so a push into an empty FIFO in
  // the same cycle is not visible to the read.
  assign pop   = rd && !address && nonempty;

  assign count8      = 8'(count);
  assign status_word = {16'h0, count8, 5'b0, in_eof, full, nonempty};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memory_out <= 32'h0;
    end else if (rd) begin
      if (address)       memory_out <= status_word;
      else if (nonempty) memory_out <= {24'h0, mem[rptr]};
      else               memory_out <= 32'hFFFF_FFFF;
    end
  end

endmodule
